wlan_sync_win_acc: RTL and testbench
====================================

// Module: wlan_sync_win_acc
//
// PURPOSE
// - Sliding-window accumulator directly downstream of the signed 16x11 product stage in the WLAN sync chain.
// - Consumes one 27-bit signed product per handshake and emits the running sum of the last WIN products.
// - Forms the moving-sum half of the short-training-symbol delay-and-correlate metric; the result feeds the sync peak detector.
//
// PARAMETERS
// - DIN_W  27  signed product width from the multiplier stage
// - WIN    16  window length in samples (power of two, 2..64)
// - OUT_W  24  saturated output width (used only when WSA_SAT_OUT_EN is defined)
// - localparam ACC_W = DIN_W + $clog2(WIN)  exact accumulator width (31 at defaults)
//
// PORTS
// - ap_clk    in   1       clock, rising edge
// - ap_rst_n  in   1       asynchronous reset, active-low
// - clr       in   1       synchronous window flush, single-cycle pulse
// - din       in   DIN_W   signed product
// - din_vld   in   1       din valid
// - din_rdy   out  1       block accepts din this cycle
// - dout      out  ACC_W   signed window sum (OUT_W if WSA_SAT_OUT_EN)
// - dout_vld  out  1       dout valid
// - dout_rdy  in   1       downstream accepts dout
// - sat       out  1       dout was clipped (present only if WSA_SAT_OUT_EN)
//
// BEHAVIOUR
// - Reset (async assert, sync release): dout=0, dout_vld=0, sat=0, acc=0, wptr=0, fill_cnt=0, state=FILL. din_rdy depends on dout_vld, so it is 1 after reset.
// - Accept: acc_fire = din_vld && din_rdy, with din_rdy = !dout_vld || dout_rdy. Single output register, no skid buffer.
// - States:
//   - FILL: fill_cnt counts accepted samples. The subtracted term is forced to 0, so stale buffer contents are never used.
//   - On the WIN-th accept, FILL -> RUN.
//   - RUN: every accept subtracts buf[wptr].
// - Per accept:
//   - acc_nx = acc + sxt(din) - (state==RUN ? sxt(buf[wptr]) : 0)
//   - buf[wptr] <= din
//   - wptr <= (wptr==WIN-1) ? 0 : wptr+1
//   - acc <= acc_nx
// - Arithmetic: full-precision two's complement in ACC_W bits, so it never overflows. Each term is sign-extended before the add.
// - Output, latency 1 cycle from accept:
//   - dout <= acc_nx
//   - dout_vld <= 1 if state==RUN or fill_cnt==WIN-1
//   - First valid output is the sum of samples 1..WIN.
// - dout_vld clears on a dout_rdy handshake with no new accept. dout holds stable while dout_vld && !dout_rdy.
// - Simultaneous output pop and input accept: dout_vld stays 1 and dout updates in the same cycle.
// - clr:
//   - Next cycle: acc=0, wptr=0, fill_cnt=0, state=FILL, dout_vld=0.
//   - clr has priority over a coincident accept; that sample is dropped.
//   - A pending unconsumed dout is discarded.
// - Reset mid-operation: identical to clr, but asynchronous.
//
// CONFIGURATION
// - WSA_SAT_OUT_EN defined:
//   - dout is OUT_W wide. Values are clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
//   - sat=1 on the same cycle as the clipped dout; sat is registered alongside dout.
//   - The internal accumulator stays ACC_W, so clipping never corrupts the running sum.
// - WSA_SAT_OUT_EN undefined: dout is the full ACC_W sum and there is no sat port.
//
// STRUCTURE
// - wlan_sync_pkg:
//   - DIN_W default
//   - state enum {FILL, RUN}
//   - function sat_clip(acc, OUT_W)
// - Sub-module wlan_sync_win_dline: WIN x DIN_W circular buffer.
//   - Write port and async read at wptr.
//   - Maps to distributed RAM; no reset on contents.
// - Top holds the FSM, fill counter, accumulator, output register and handshake.
//
// TESTING
// Each scenario lists stimulus -> required response, at defaults (WIN=16).
// - Reset: hold ap_rst_n=0 for 3 cycles -> dout=0, dout_vld=0, din_rdy=1.
// - Fill:
//   - 16 x din=+1000, dout_rdy=1 -> dout_vld low for the first 15 accepts; first dout=16000 one cycle after the 16th accept.
//   - Follow with 16 x din=-1000 -> dout steps 14000, 12000, ..., -16000.
// - Extremes: 16 x din=-2^26 -> dout=-2^30 exactly. Then 16 x din=2^26-1 -> dout=2^30-16, with no wrap.
// - Backpressure:
//   - Continuous din_vld with dout_rdy low for 5 cycles -> din_rdy=0 and dout held for those 5 cycles.
//   - No sample is lost or duplicated; compare against a reference-model sum.
// - clr mid-run:
//   - After 20 samples, pulse clr together with din_vld -> that sample is dropped and dout_vld=0 next cycle.
//   - The next valid output needs 16 fresh accepts.
// - WSA_SAT_OUT_EN, OUT_W=24:
//   - 16 x din=2^26-1 -> dout=2^23-1, sat=1.
//   - Then 16 x din=0 -> dout=0, sat=0.

Source files
------------

// File: rtl/wlan_sync_pkg.sv
// Shared types and helpers for the WLAN sync sliding-window accumulator.
package wlan_sync_pkg;

  localparam int unsigned WSA_DIN_W = 27;

  typedef enum logic {
    StFill,
    StRun
  } wsa_state_e;

  // Clip a sign-extended sum into the signed range of out_w bits.
  function automatic logic signed [63:0] sat_clip(input logic signed [63:0] acc,
                                                  input int unsigned out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (acc > hi) begin
      return hi;
    end else if (acc < lo) begin
      return lo;
    end else begin
      return acc;
    end
  endfunction

endpackage

// File: rtl/wlan_sync_win_dline.sv
// WIN-deep circular sample buffer: synchronous write, asynchronous read at the same address.
module wlan_sync_win_dline #(
  parameter int unsigned DIN_W = 27,
  parameter int unsigned WIN   = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(WIN)-1:0]   addr,
  input  logic signed [DIN_W-1:0]  wdata,
  output logic signed [DIN_W-1:0]  rdata
);

  logic [DIN_W-1:0] mem [WIN];

  // Contents are never reset; the FILL state guarantees stale entries are not read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/wlan_sync_win_acc.sv
// Sliding-window sum of the last WIN signed products with a single-register valid/ready output.
// Optional output clipping to OUT_W bits with a sat flag when WSA_SAT_OUT_EN is defined.
module wlan_sync_win_acc
  import wlan_sync_pkg::*;
#(
  parameter int unsigned DIN_W = WSA_DIN_W,
  parameter int unsigned WIN   = 16,
  parameter int unsigned OUT_W = 24
) (
  input  logic                                 ap_clk,
  input  logic                                 ap_rst_n,
  input  logic                                 clr,
  input  logic signed [DIN_W-1:0]              din,
  input  logic                                 din_vld,
  output logic                                 din_rdy,
`ifdef WSA_SAT_OUT_EN
  output logic signed [OUT_W-1:0]              dout,
  output logic                                 sat,
`else
  output logic signed [DIN_W+$clog2(WIN)-1:0]  dout,
`endif
  output logic                                 dout_vld,
  input  logic                                 dout_rdy
);

  localparam int unsigned ACC_W = DIN_W + $clog2(WIN);
  localparam int unsigned PTR_W = $clog2(WIN);
`ifdef WSA_SAT_OUT_EN
  localparam int unsigned DOUT_W = OUT_W;
`else
  localparam int unsigned DOUT_W = ACC_W;
`endif

  if (WIN < 2 || WIN > 64 || (WIN & (WIN - 1)) != 0) begin : g_bad_win
    $error("WIN must be a power of two in 2..64");
  end
  if (OUT_W < 2 || OUT_W > ACC_W) begin : g_bad_out_w
    $error("OUT_W must be in 2..ACC_W");
  end

  wsa_state_e                state_q, state_d;
  logic [PTR_W-1:0]          fill_q, fill_d;
  logic [PTR_W-1:0]          wptr_q, wptr_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d, acc_nx;
  logic signed [DOUT_W-1:0]  dout_q, dout_d, dout_nx;
  logic                      dout_vld_q, dout_vld_d;
  logic                      sat_q, sat_d, sat_nx;

  logic                      acc_fire;
  logic                      last_fill;
  logic signed [DIN_W-1:0]   buf_rd;
  logic signed [ACC_W-1:0]   din_ext;
  logic signed [ACC_W-1:0]   sub_ext;

  assign din_rdy   = !dout_vld_q || dout_rdy;
  assign acc_fire  = din_vld && din_rdy && !clr;
  assign last_fill = (fill_q == PTR_W'(WIN - 1));

  wlan_sync_win_dline #(
    .DIN_W (DIN_W),
    .WIN   (WIN)
  ) u_dline (
    .clk   (ap_clk),
    .we    (acc_fire),
    .addr  (wptr_q),
    .wdata (din),
    .rdata (buf_rd)
  );

  always_comb begin
    din_ext = {{(ACC_W - DIN_W){din[DIN_W-1]}}, din};
    sub_ext = '0;
    if (state_q == StRun) begin
      sub_ext = {{(ACC_W - DIN_W){buf_rd[DIN_W-1]}}, buf_rd};
    end
    acc_nx = acc_q + din_ext - sub_ext;
  end

`ifdef WSA_SAT_OUT_EN
  logic signed [63:0] acc_wide;
  logic signed [63:0] acc_clip;

  always_comb begin
    acc_wide = {{(64 - ACC_W){acc_nx[ACC_W-1]}}, acc_nx};
    acc_clip = sat_clip(acc_wide, OUT_W);
    dout_nx  = acc_clip[OUT_W-1:0];
    sat_nx   = (acc_clip != acc_wide);
  end

  assign sat = sat_q;
`else
  always_comb begin
    dout_nx = acc_nx;
    sat_nx  = 1'b0;
  end
`endif

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    wptr_d     = wptr_q;
    acc_d      = acc_q;
    dout_d     = dout_q;
    dout_vld_d = dout_vld_q;
    sat_d      = sat_q;
    // clr wins over a coincident accept and drops any pending output.
    if (clr) begin
      state_d    = StFill;
      fill_d     = '0;
      wptr_d     = '0;
      acc_d      = '0;
      dout_vld_d = 1'b0;
    end else if (acc_fire) begin
      acc_d      = acc_nx;
      wptr_d     = (wptr_q == PTR_W'(WIN - 1)) ? '0 : wptr_q + 1'b1;
      dout_d     = dout_nx;
      sat_d      = sat_nx;
      dout_vld_d = (state_q == StRun) || last_fill;
      if (state_q == StFill) begin
        fill_d = fill_q + 1'b1;
        if (last_fill) begin
          state_d = StRun;
        end
      end
    end else if (dout_rdy) begin
      dout_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StFill;
      fill_q     <= '0;
      wptr_q     <= '0;
      acc_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      wptr_q     <= wptr_d;
      acc_q      <= acc_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      sat_q      <= sat_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_wlan_sync_win_acc.sv
// Directed self-checking bench for wlan_sync_win_acc at WIN=16 (WSA_SAT_OUT_EN adds clip checks).
module tb_wlan_sync_win_acc;

  localparam int DIN_W = 27;
  localparam int WIN   = 16;
`ifdef WSA_SAT_OUT_EN
  localparam int DOUT_W = 24;
`else
  localparam int DOUT_W = 31;
`endif

  logic                      ap_clk = 1'b0;
  logic                      ap_rst_n = 1'b0;
  logic                      clr = 1'b0;
  logic signed [DIN_W-1:0]   din = '0;
  logic                      din_vld = 1'b0;
  logic                      din_rdy;
  logic signed [DOUT_W-1:0]  dout;
  logic                      dout_vld;
  logic                      dout_rdy = 1'b1;
`ifdef WSA_SAT_OUT_EN
  logic                      sat;
`endif

  int     n_chk = 0;
  int     n_fail = 0;
  longint hist[$];
  longint msum = 0;

  always #5 ap_clk = ~ap_clk;

  wlan_sync_win_acc #(
    .DIN_W (DIN_W),
    .WIN   (WIN),
    .OUT_W (24)
  ) u_dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .clr      (clr),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .dout     (dout),
`ifdef WSA_SAT_OUT_EN
    .sat      (sat),
`endif
    .dout_vld (dout_vld),
    .dout_rdy (dout_rdy)
  );

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_out(input longint s);
`ifdef WSA_SAT_OUT_EN
    if (s > 64'sd8388607) return 64'sd8388607;
    if (s < -64'sd8388608) return -64'sd8388608;
`endif
    return s;
  endfunction

  task automatic model_push(input longint val);
    hist.push_back(val);
    msum += val;
    if (hist.size() > WIN) msum -= hist.pop_front();
  endtask

  task automatic model_clear();
    hist.delete();
    msum = 0;
  endtask

  task automatic check_out(input string tag);
    check_eq({tag, "_vld"}, longint'(dout_vld), longint'(hist.size() == WIN));
    if (hist.size() == WIN) begin
      check_eq({tag, "_dout"}, longint'(dout), exp_out(msum));
`ifdef WSA_SAT_OUT_EN
      check_eq({tag, "_sat"}, longint'(sat), longint'(exp_out(msum) != msum));
`endif
    end
  endtask

  // Called #1 after a rising edge; leaves time at #1 after the accepting edge.
  task automatic push(input longint val, input string tag);
    din     = DIN_W'(val);
    din_vld = 1'b1;
    #1;
    check_eq({tag, "_rdy"}, longint'(din_rdy), 1);
    @(posedge ap_clk);
    #1;
    din_vld = 1'b0;
    model_push(val);
    check_out(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    check_eq("rst_dout", longint'(dout), 0);
    check_eq("rst_vld", longint'(dout_vld), 0);
    check_eq("rst_rdy", longint'(din_rdy), 1);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    for (int i = 0; i < WIN; i++) push(1000, "fill");
    check_eq("fill_first", longint'(dout), 16000);
    for (int i = 0; i < WIN; i++) push(-1000, "drain");
    check_eq("drain_last", longint'(dout), -16000);

    for (int i = 0; i < WIN; i++) push(-(64'sd1 <<< 26), "neg_max");
`ifndef WSA_SAT_OUT_EN
    check_eq("neg_max_sum", longint'(dout), -(64'sd1 <<< 30));
`endif
    for (int i = 0; i < WIN; i++) push((64'sd1 <<< 26) - 1, "pos_max");
`ifdef WSA_SAT_OUT_EN
    check_eq("pos_clip", longint'(dout), 8388607);
    check_eq("pos_clip_sat", longint'(sat), 1);
`else
    check_eq("pos_max_sum", longint'(dout), (64'sd1 <<< 30) - 16);
`endif
    for (int i = 0; i < WIN; i++) push(0, "zero");
    check_eq("zero_sum", longint'(dout), 0);
`ifdef WSA_SAT_OUT_EN
    check_eq("zero_sat", longint'(sat), 0);
`endif

    // Backpressure: output held, input stalled for 5 cycles.
    for (int i = 0; i < 4; i++) push(i * 311 - 500, "pre_bp");
    dout_rdy = 1'b0;
    din      = DIN_W'(1234);
    din_vld  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("bp_rdy", longint'(din_rdy), 0);
      @(posedge ap_clk);
      #1;
      check_eq("bp_hold", longint'(dout), exp_out(msum));
      check_eq("bp_vld", longint'(dout_vld), 1);
    end
    dout_rdy = 1'b1;
    #1;
    check_eq("bp_release_rdy", longint'(din_rdy), 1);
    @(posedge ap_clk);
    #1;
    din_vld = 1'b0;
    model_push(1234);
    check_out("bp_release");
    for (int i = 0; i < 10; i++) push(i * 37 - 150, "post_bp");

    // Pop with no new accept clears dout_vld.
    @(posedge ap_clk);
    #1;
    check_eq("pop_vld", longint'(dout_vld), 0);
    check_eq("pop_rdy", longint'(din_rdy), 1);
    push(42, "after_pop");

    // clr with a coincident sample: sample dropped, refill needed.
    clr     = 1'b1;
    din     = DIN_W'(999);
    din_vld = 1'b1;
    @(posedge ap_clk);
    #1;
    clr     = 1'b0;
    din_vld = 1'b0;
    check_eq("clr_vld", longint'(dout_vld), 0);
    model_clear();
    for (int i = 0; i < WIN; i++) push((i + 1) * 100 - 700, "refill");
    check_eq("refill_sum", longint'(dout), 2400);

    // Asynchronous reset mid-run behaves like clr.
    for (int i = 0; i < 3; i++) push(77 * i, "pre_rst");
    #3;
    ap_rst_n = 1'b0;
    #1;
    check_eq("arst_vld", longint'(dout_vld), 0);
    check_eq("arst_dout", longint'(dout), 0);
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    model_clear();
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < WIN; i++) push(5, "post_rst");
    check_eq("post_rst_sum", longint'(dout), 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
